branch_predict_unit: RTL

Parametrised branch resolution and prediction block for the MIPS pipeline. It resolves the full MIPS conditional-branch set (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL) on operands of configurable width, with one registered stage. It maintains a table of 2-bit saturating predictors indexed by PC and flags mispredictions against the prediction fetch made. It sits beside decode/execute: fetch reads predictions, and the resolve stage feeds outcomes back.

---
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolve stage with one registered stage and a PC-indexed table of
// 2-bit saturating predictors, plus saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int unsigned DW       = 32,
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pred_pc,
    output logic          pred_taken,
    input  logic          res_valid,
    input  logic [31:0]   res_pc,
    input  logic [5:0]    op,
    input  logic [4:0]    rt,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          res_pred_taken,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic          br_taken,
    output logic          mispredict,
    output logic [31:0]   br_cnt,
    output logic [31:0]   miss_cnt
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_tbl [DEPTH];
    logic             is_branch;
    logic             taken;
    logic             accept;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] pred_idx;
    logic             s_valid;
    logic             s_taken;
    logic             s_mis;
    logic [IDX_W-1:0] s_idx;
    logic [1:0]       upd_cnt;
    logic [31:0]      br_reg;
    logic [31:0]      br_d;
    logic [31:0]      miss_reg;
    logic [31:0]      miss_d;
    logic             unused;

    assign res_idx  = res_pc[IDX_W+1:2];
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign unused   = ^{res_pc[31:IDX_W+2], res_pc[1:0], pred_pc[31:IDX_W+2], pred_pc[1:0]};

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (op)
            6'b000100: begin is_branch = 1'b1; taken = (a == b);                   end
            6'b000101: begin is_branch = 1'b1; taken = (a != b);                   end
            6'b000110: begin is_branch = 1'b1; taken = a[DW-1] | (a == '0);        end
            6'b000111: begin is_branch = 1'b1; taken = !a[DW-1] && (a != '0);      end
            6'b000001: begin
                case (rt)
                    5'b00000, 5'b10000: begin is_branch = 1'b1; taken = a[DW-1];  end
                    5'b00001, 5'b10001: begin is_branch = 1'b1; taken = !a[DW-1]; end
                    default:            begin is_branch = 1'b0; taken = 1'b0;     end
                endcase
            end
            default: begin is_branch = 1'b0; taken = 1'b0; end
        endcase
    end

    assign accept = res_valid & is_branch & ~stall & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_taken <= 1'b0;
            s_mis   <= 1'b0;
            s_idx   <= '0;
        end else begin
            s_valid <= accept;
            if (accept) begin
                s_taken <= taken;
                s_mis   <= taken ^ res_pred_taken;
                s_idx   <= res_idx;
            end
        end
    end

    always_comb begin
        upd_cnt = cnt_tbl[s_idx];
        if (s_taken) begin
            if (cnt_tbl[s_idx] != 2'b11) upd_cnt = cnt_tbl[s_idx] + 2'd1;
        end else begin
            if (cnt_tbl[s_idx] != 2'b00) upd_cnt = cnt_tbl[s_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) cnt_tbl[i] <= CNT_INIT;
        end else if (s_valid) begin
            cnt_tbl[s_idx] <= upd_cnt;
        end
    end

    // Bypass lets fetch see the update committing at the end of this cycle.
    assign pred_taken = (s_valid && (pred_idx == s_idx)) ? upd_cnt[1] : cnt_tbl[pred_idx][1];

    always_comb begin
        br_d   = br_reg;
        miss_d = miss_reg;
        if (s_valid) begin
            if (br_reg != 32'hFFFF_FFFF) br_d = br_reg + 32'd1;
            if (s_mis && (miss_reg != 32'hFFFF_FFFF)) miss_d = miss_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_reg   <= '0;
            miss_reg <= '0;
        end else begin
            br_reg   <= br_d;
            miss_reg <= miss_d;
        end
    end

    assign out_valid  = s_valid;
    assign br_taken   = s_taken;
    assign mispredict = s_mis;
    assign br_cnt     = br_reg;
    assign miss_cnt   = miss_reg;

endmodule
